hazard_unit: RTL and testbench

- Pipeline hazard controller in the ID/EX region of the RISC-V core.
- Produces selOp for the control-bubble mux, which zeroes the ID-stage control word when selOp=1.
- Also produces write enables for the PC and the pipeline registers, and flushes for IF/ID and ID/EX.
- Handles three hazards: load-use stalls, taken-branch flushes, and multi-cycle data-memory wait stalls.
- Keeps stall/flush performance counters and a sticky memory-timeout error flag.

---
 rtl/hazard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the ID/EX region: load-use stalls, taken-branch flushes
// and data-memory wait stalls, with stall/flush counters and a sticky timeout flag.
//
// state | meaning
// RUN   | normal issue; a taken branch flushes this cycle and may enter FLUSH
// FLUSH | extra branch-penalty cycles still being flushed (flush_cnt remaining)
module hazard_unit #(
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUsesRs2,
  input  logic [4:0]       exRd,
  input  logic             exMemRead,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             selOp,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExWrite,
  output logic             exMemWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [1:0]        flush_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_stall;
  logic load_use;
  logic flush_now;
  logic stall_inc;
  logic flush_inc;

  assign mem_stall = memReq & ~memReady;
  assign load_use  = exMemRead & (exRd != 5'd0) &
                     ((exRd == idRs1) | (idUsesRs2 & (exRd == idRs2)));
  assign flush_now = branchTaken | (state == FLUSH);
  assign stall_inc = mem_stall | (load_use & ~flush_now);
  assign flush_inc = flush_now & ~mem_stall;

  // Outputs are decoded directly from state and inputs so hazards act in the same cycle.
  always_comb begin
    selOp      = 1'b0;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExWrite  = 1'b1;
    exMemWrite = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    if (!rst_n) begin
      selOp      = 1'b1;
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
    end else if (mem_stall) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
    end else if (flush_now) begin
      selOp     = 1'b1;
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use) begin
      selOp     = 1'b1;
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
    end else if (!mem_stall) begin
      case (state)
        RUN: begin
          if (branchTaken && (BR_PENALTY > 1)) begin
            state     <= FLUSH;
            flush_cnt <= 2'(BR_PENALTY - 1);
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 2'd1;
          if (flush_cnt == 2'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // wait_cnt saturates so a very long stall can never wrap back through the trip point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      memErr   <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) memErr <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles <= '0;
      flushCycles <= '0;
    end else begin
      if (stall_inc && (stallCycles != '1)) stallCycles <= stallCycles + 1'b1;
      if (flush_inc && (flushCycles != '1)) flushCycles <= flushCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver pushes expected outputs from a
// behavioural model, and a separate monitor pops and compares them each cycle.
module tb_hazard_unit;

  localparam int BRP   = 2;
  localparam int MTO   = 4;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    idRs1 = '0, idRs2 = '0, exRd = '0;
  logic          idUsesRs2 = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
  logic          memReq = 1'b0, memReady = 1'b0;
  logic          selOp, pcWrite, ifIdWrite, idExWrite, exMemWrite;
  logic          ifIdFlush, idExFlush, memErr;
  logic [CW-1:0] stallCycles, flushCycles;

  hazard_unit #(.BR_PENALTY(BRP), .MEM_TIMEOUT(MTO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs2(idUsesRs2),
    .exRd(exRd), .exMemRead(exMemRead), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .selOp(selOp), .pcWrite(pcWrite),
    .ifIdWrite(ifIdWrite), .idExWrite(idExWrite), .exMemWrite(exMemWrite),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .memErr(memErr),
    .stallCycles(stallCycles), .flushCycles(flushCycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          tag;
    logic [7:0]  ctl;   // {selOp,pcWrite,ifIdWrite,idExWrite,exMemWrite,ifIdFlush,idExFlush,memErr}
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 1'b0;

  // Model state: penalty cycles still owed, consecutive wait cycles, sticky error, counters.
  int m_flush_left = 0, m_wait = 0, m_err = 0, m_stall = 0, m_flush = 0;

  task automatic cyc(input int tag, input bit rst, input int rs1, input int rs2,
                     input bit uses2, input int rd, input bit ld, input bit br,
                     input bit req, input bit rdy);
    exp_t e;
    bit ms, lu, fn;
    int nf, nw, ne, ns, nfl;
    @(negedge clk);
    rst_n = rst; idRs1 = 5'(rs1); idRs2 = 5'(rs2); idUsesRs2 = uses2;
    exRd = 5'(rd); exMemRead = ld; branchTaken = br; memReq = req; memReady = rdy;
    #1;
    e.tag = tag;
    if (!rst) begin
      m_flush_left = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
      e.ctl = 8'b1000_0000; e.st = '0; e.fl = '0;
      nf = 0; nw = 0; ne = 0; ns = 0; nfl = 0;
    end else begin
      ms = req && !rdy;
      lu = ld && rd != 0 && (rd == rs1 || (uses2 && rd == rs2));
      fn = br || m_flush_left > 0;
      if (ms)      e.ctl = 8'b0000_0000;
      else if (fn) e.ctl = 8'b1111_1110;
      else if (lu) e.ctl = 8'b1001_1000;
      else         e.ctl = 8'b0111_1000;
      e.ctl[0] = (m_err != 0);
      e.st = CW'(m_stall); e.fl = CW'(m_flush);
      nf = m_flush_left; nw = m_wait; ne = m_err; ns = m_stall; nfl = m_flush;
      if (!ms) begin
        if (m_flush_left > 0) nf = m_flush_left - 1;
        else if (br) nf = BRP - 1;
      end
      if (ms) begin
        if (m_wait == MTO - 1) ne = 1;
        nw = m_wait + 1;
      end else nw = 0;
      if (ms || (lu && !fn)) ns = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (fn && !ms) nfl = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
    exp_q.push_back(e);
    @(posedge clk);
    m_flush_left = nf; m_wait = nw; m_err = ne; m_stall = ns; m_flush = nfl;
  endtask

  task automatic idle(input int tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0] act;
    while (!done) begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {selOp, pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush, memErr};
        n_checks++;
        if (act !== e.ctl || stallCycles !== e.st || flushCycles !== e.fl) begin
          n_errors++;
          $display("FAIL phase%0d t=%0t: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                   e.tag, $time, act, stallCycles, flushCycles, e.ctl, e.st, e.fl);
        end
      end
    end
  end

  initial begin : driver
    int wait_budget;
    // tag, rst, rs1, rs2, uses2, rd, ld, br, req, rdy
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1);
    cyc(1, 1, 5, 0, 0, 5, 1, 0, 0, 0);     // load-use on rs1
    idle(1, 1);
    cyc(2, 1, 0, 0, 0, 0, 1, 0, 0, 0);     // rd=x0 never stalls
    cyc(3, 1, 0, 7, 0, 7, 1, 0, 0, 0);     // rs2 not read
    cyc(3, 1, 0, 7, 1, 7, 1, 0, 0, 0);     // rs2 read
    idle(3, 1);
    cyc(4, 1, 0, 0, 0, 0, 0, 1, 0, 0);     // branch pulse
    cyc(4, 1, 0, 0, 0, 0, 0, 1, 0, 0);     // wrong-path branch ignored
    idle(4, 2);
    for (int i = 0; i < 3; i++) cyc(5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(5, 1);
    for (int i = 0; i < 4; i++) cyc(6, 1, 3, 0, 0, 3, 1, 1, 1, 0);
    cyc(6, 1, 3, 0, 0, 3, 1, 1, 1, 1);     // first free cycle acts on the branch
    cyc(6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6, 1);
    cyc(7, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(7, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(7, 0, 0, 0, 0, 0, 0, 0, 1, 0);     // reset mid-stall
    cyc(7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit rst;
      rst = ($urandom_range(0, 199) != 0);
      cyc(8, rst, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
          $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
    end
    wait_budget = 0;
    while (exp_q.size() > 0 && wait_budget < 20) begin
      @(posedge clk);
      wait_budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    done = 1'b1;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
